wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter LOADW, default 3, width of the load-type code.
REQ-002 SHALL have port clk input 1: single clock; stage register and scoreboard update on posedge.
REQ-003 SHALL have port rst input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid input 1: MEM stage presents an instruction.
REQ-005 SHALL have port hold input 1: freeze the stage register and scoreboard clears.
REQ-006 SHALL have port flush input 1: discard the incoming instruction.
REQ-007 SHALL have port reg_write input 1: the instruction writes a GPR.
REQ-008 SHALL have port dst input 5: destination register number.
REQ-009 SHALL have port wd_sel input 2: write-data source; 0 ALU, 1 MEM, 2 PC+4, 3 reserved (treated as ALU).
REQ-010 SHALL have port ld_type input LOADW: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; other codes treated as LW.
REQ-011 SHALL have port alu_res input 32: ALU result; bits [1:0] give the load byte offset.
REQ-012 SHALL have port mem_rdata input 32: raw aligned memory word, little-endian.
REQ-013 SHALL have port pc4 input 32: link value.
REQ-014 SHALL have port iss_valid input 1: decode issues a GPR producer.
REQ-015 SHALL have port iss_dst input 5: register number of that producer.
REQ-016 SHALL have port RFWr output 1: register-file write enable.
REQ-017 SHALL have port A3 output 5: register-file write address.
REQ-018 SHALL have port WD output 32: register-file write data.
REQ-019 SHALL have port busy output 32: scoreboard; bit i set means a write to ri is pending.
REQ-020 SHALL have port misalign output 1: the held load is misaligned; its write is suppressed.
REQ-021 SHALL have port retired output 32: count of instructions retired.

Function
REQ-022 SHALL capture all inputs at posedge clk when hold=0; the captured state is the stage register.
REQ-023 SHALL drive RFWr, A3 and WD only from the stage register, with no combinational path from any input.
REQ-024 SHALL assert RFWr = v & rw & (A3!=0) & ~misalign.
- v and rw are the captured in_valid&~flush and reg_write.
- The register file commits at the following negedge, so latency is capture posedge to write in half a cycle.
REQ-025 SHALL select WD as follows: wd_sel=0/3 gives alu_res; wd_sel=2 gives pc4; wd_sel=1 gives the load-extended value.
REQ-026 SHALL extend loads as follows, with off=alu_res[1:0]:
- LW: the whole word.
- LH/LHU: halfword mem_rdata[16*off[1]+:16], sign- or zero-extended.
- LB/LBU: byte mem_rdata[8*off+:8], sign- or zero-extended.
REQ-027 SHALL flag misalign when wd_sel=1 and either LW has off!=0, or LH/LHU has off[0]=1; misalign is combinational from the stage register.
REQ-028 SHALL hold all stage outputs constant while hold=1; RFWr stays asserted, and a repeated RF write of the same value is permitted.
REQ-029 SHALL capture an invalid entry when flush=1 and hold=0; the entry produces no write and no retirement.
REQ-030 SHALL update busy at posedge, with set evaluated after clear:
- Clear: bit A3 clears when the stage register holds v&rw and hold=0 (entry leaves), including when misalign=1.
- Set: bit iss_dst sets when iss_valid=1.
- When set and clear hit the same register in one cycle, set wins.
- Issue to r0 is ignored; busy[0] is always 0.
REQ-031 SHALL increment retired (wrapping modulo 2^32) at each posedge where the stage register holds v=1 and hold=0; misaligned entries count.

Reset
REQ-032 SHALL, while rst=0, asynchronously force v=0, busy=0 and retired=0, with RFWr=0, A3=0, WD=0 and misalign=0.
REQ-033 SHALL resume capture at the first posedge after rst rises.
REQ-034 SHALL discard an entry in flight when reset is asserted mid-operation, with no RF write.

Verification
REQ-035 SHALL pass: LB with off=3, mem_rdata=0x80FF_1234, dst=5 -> WD=0xFFFF_FF80, RFWr=1, A3=5 for one cycle.
REQ-036 SHALL pass: LHU with off=2, mem_rdata=0x9ABC_0000 -> WD=0x0000_9ABC; LH with off=1 -> misalign=1, RFWr=0, retired incremented.
REQ-037 SHALL pass: iss_valid with iss_dst=8, then a writeback of r8 in the same cycle as a new issue of r8 -> busy[8] remains 1; a later writeback alone -> busy[8]=0.
REQ-038 SHALL pass: an entry held for 3 cycles -> outputs unchanged, busy bit not cleared and retired unchanged until hold drops.
REQ-039 SHALL pass: dst=0 with reg_write=1 -> RFWr=0, retired+1; flush=1 -> v=0, retired unchanged.
REQ-040 SHALL pass: rst low mid-stream with busy=0x0000_0120 and retired=7 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback stage register with load extension, misalign suppression, GPR scoreboard and retire counter.
module wb_stage #(
  parameter int LOADW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             hold,
  input  logic             flush,
  input  logic             reg_write,
  input  logic [4:0]       dst,
  input  logic [1:0]       wd_sel,
  input  logic [LOADW-1:0] ld_type,
  input  logic [31:0]      alu_res,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      pc4,
  input  logic             iss_valid,
  input  logic [4:0]       iss_dst,
  output logic             RFWr,
  output logic [4:0]       A3,
  output logic [31:0]      WD,
  output logic [31:0]      busy,
  output logic             misalign,
  output logic [31:0]      retired
);
  logic             v, rw;
  logic [1:0]       sel;
  logic [LOADW-1:0] lt;
  logic [31:0]      alu, md, pc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v   <= 1'b0;
      rw  <= 1'b0;
      A3  <= '0;
      sel <= '0;
      lt  <= '0;
      alu <= '0;
      md  <= '0;
      pc  <= '0;
    end else if (!hold) begin
      v   <= in_valid & ~flush;
      rw  <= reg_write;
      A3  <= dst;
      sel <= wd_sel;
      lt  <= ld_type;
      alu <= alu_res;
      md  <= mem_rdata;
      pc  <= pc4;
    end
  logic [1:0]  off;
  logic [15:0] half;
  logic [7:0]  byt;
  logic        is_lh, is_lhu, is_lb, is_lbu, is_word;
  logic [31:0] ld_val;
  always_comb begin
    off     = alu[1:0];
    half    = off[1] ? md[31:16] : md[15:0];
    byt     = md[8*off +: 8];
    is_lh   = lt == LOADW'(1);
    is_lhu  = lt == LOADW'(2);
    is_lb   = lt == LOADW'(3);
    is_lbu  = lt == LOADW'(4);
    is_word = ~(is_lh | is_lhu | is_lb | is_lbu);
    ld_val  = is_lh  ? {{16{half[15]}}, half} :
              is_lhu ? {16'h0, half} :
              is_lb  ? {{24{byt[7]}}, byt} :
              is_lbu ? {24'h0, byt} : md;
    WD       = sel == 2'd2 ? pc : sel == 2'd1 ? ld_val : alu;
    misalign = sel == 2'd1 & ((is_word & |off) | ((is_lh | is_lhu) & off[0]));
    RFWr     = v & rw & |A3 & ~misalign;
  end
  // set is applied after clear so a same-cycle reissue keeps the bit pending
  logic [31:0] busy_nxt;
  always_comb begin
    busy_nxt = busy;
    if (v & rw & ~hold) busy_nxt[A3] = 1'b0;
    if (iss_valid) busy_nxt[iss_dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy    <= '0;
      retired <= '0;
    end else begin
      busy <= busy_nxt;
      if (v & ~hold) retired <= retired + 32'd1;
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;
  logic        clk = 1'b0, rst, in_valid, hold, flush, reg_write, iss_valid;
  logic [4:0]  dst, iss_dst;
  logic [1:0]  wd_sel;
  logic [2:0]  ld_type;
  logic [31:0] alu_res, mem_rdata, pc4;
  logic        RFWr, misalign;
  logic [4:0]  A3;
  logic [31:0] WD, busy, retired;
  int errs = 0, checks = 0;
  logic [31:0] exp_ret = 0;
  wb_stage #(.LOADW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .hold(hold), .flush(flush),
    .reg_write(reg_write), .dst(dst), .wd_sel(wd_sel), .ld_type(ld_type),
    .alu_res(alu_res), .mem_rdata(mem_rdata), .pc4(pc4), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .RFWr(RFWr), .A3(A3), .WD(WD), .busy(busy),
    .misalign(misalign), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic iv, input logic w, input logic [4:0] d, input logic [1:0] s,
                        input logic [2:0] l, input logic [31:0] a, input logic [31:0] m, input logic [31:0] p);
    in_valid = iv; reg_write = w; dst = d; wd_sel = s; ld_type = l; alu_res = a; mem_rdata = m; pc4 = p;
  endtask
  task automatic idle;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    hold = 0; flush = 0; iss_valid = 0; iss_dst = 0;
  endtask
  task automatic test_reset;
    rst = 0;
    idle();
    set_in(1, 1, 5'd3, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0);
    tick();
    checks++; if (RFWr !== 1'b0) begin errs++; $display("FAIL reset_rfwr got=%b exp=0", RFWr); end
    checks++; if (A3 !== 5'd0) begin errs++; $display("FAIL reset_a3 got=%0d exp=0", A3); end
    checks++; if (WD !== 32'h0) begin errs++; $display("FAIL reset_wd got=%h exp=0", WD); end
    checks++; if (busy !== 32'h0) begin errs++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (misalign !== 1'b0) begin errs++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    checks++; if (retired !== 32'h0) begin errs++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    rst = 1;
    tick();
    checks++; if (RFWr !== 1'b1 || A3 !== 5'd3 || WD !== 32'h55) begin errs++; $display("FAIL resume_capture got rfwr=%b a3=%0d wd=%h exp 1/3/55", RFWr, A3, WD); end
    idle();
    tick();
    exp_ret = 1;
    checks++; if (retired !== exp_ret) begin errs++; $display("FAIL resume_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask
  task automatic test_lb;
    set_in(1, 1, 5'd5, 2'd1, 3'd3, 32'h103, 32'h80FF_1234, 32'h0);
    tick();
    checks++; if (WD !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb_wd got=%h exp=ffffff80", WD); end
    checks++; if (RFWr !== 1'b1 || A3 !== 5'd5) begin errs++; $display("FAIL lb_write got rfwr=%b a3=%0d exp 1/5", RFWr, A3); end
    idle();
    tick();
    exp_ret++;
    checks++; if (RFWr !== 1'b0) begin errs++; $display("FAIL lb_one_cycle got=%b exp=0", RFWr); end
    checks++; if (retired !== exp_ret) begin errs++; $display("FAIL lb_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask
  task automatic test_loads;
    logic [1:0]  s [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0, 3};
    logic [2:0]  l [13] = '{2, 1, 1, 4, 3, 3, 0, 7, 0, 1, 0, 0, 0};
    logic [31:0] a [13] = '{2, 2, 0, 3, 1, 2, 0, 0, 2, 1, 32'h11, 32'h2233, 32'h4455};
    logic [31:0] m [13] = '{32'h9ABC_0000, 32'h9ABC_0000, 32'h0000_8001, 32'h80FF_1234, 32'h80FF_1234,
                            32'h80FF_1234, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0000_8123,
                            32'h0, 32'h0, 32'h0};
    logic [31:0] e [13] = '{32'h0000_9ABC, 32'hFFFF_9ABC, 32'hFFFF_8001, 32'h0000_0080, 32'h0000_0012,
                            32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'hFFFF_8123,
                            32'h0000_1004, 32'h0000_2233, 32'h0000_4455};
    logic        x [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      set_in(1, 1, 5'd7, s[i], l[i], a[i], m[i], 32'h1004);
      tick();
      checks++; if (WD !== e[i]) begin errs++; $display("FAIL load_wd[%0d] got=%h exp=%h", i, WD, e[i]); end
      checks++; if (misalign !== x[i] || RFWr !== ~x[i]) begin errs++; $display("FAIL load_mis[%0d] got mis=%b rfwr=%b exp mis=%b", i, misalign, RFWr, x[i]); end
      idle();
      tick();
      exp_ret++;
      checks++; if (retired !== exp_ret) begin errs++; $display("FAIL load_retired[%0d] got=%0d exp=%0d", i, retired, exp_ret); end
    end
  endtask
  task automatic test_scoreboard;
    iss_valid = 1; iss_dst = 5'd8;
    tick();
    checks++; if (busy !== 32'h100) begin errs++; $display("FAIL sb_set got=%h exp=100", busy); end
    iss_dst = 5'd0;
    set_in(1, 1, 5'd8, 2'd0, 3'd0, 32'h8, 32'h0, 32'h0);
    tick();
    checks++; if (busy !== 32'h100) begin errs++; $display("FAIL sb_r0 got=%h exp=100", busy); end
    iss_dst = 5'd8;
    tick();
    checks++; if (busy !== 32'h100) begin errs++; $display("FAIL sb_set_wins got=%h exp=100", busy); end
    idle();
    tick();
    checks++; if (busy !== 32'h0) begin errs++; $display("FAIL sb_clear got=%h exp=0", busy); end
    exp_ret += 2;
    checks++; if (retired !== exp_ret) begin errs++; $display("FAIL sb_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask
  task automatic test_hold;
    iss_valid = 1; iss_dst = 5'd9;
    set_in(1, 1, 5'd9, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
    tick();
    iss_valid = 0;
    hold = 1;
    set_in(1, 1, 5'd3, 2'd2, 3'd0, 32'hFFFF, 32'hFFFF, 32'hAAAA);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (RFWr !== 1'b1 || A3 !== 5'd9 || WD !== 32'h1234) begin errs++; $display("FAIL hold_out[%0d] got rfwr=%b a3=%0d wd=%h exp 1/9/1234", i, RFWr, A3, WD); end
      checks++; if (busy !== 32'h200 || retired !== exp_ret) begin errs++; $display("FAIL hold_state[%0d] got busy=%h ret=%0d exp 200/%0d", i, busy, retired, exp_ret); end
    end
    idle();
    tick();
    exp_ret++;
    checks++; if (busy !== 32'h0 || retired !== exp_ret || RFWr !== 1'b0) begin errs++; $display("FAIL hold_release got busy=%h ret=%0d rfwr=%b exp 0/%0d/0", busy, retired, RFWr, exp_ret); end
  endtask
  task automatic test_zero_flush;
    set_in(1, 1, 5'd0, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0);
    tick();
    checks++; if (RFWr !== 1'b0) begin errs++; $display("FAIL r0_rfwr got=%b exp=0", RFWr); end
    idle();
    tick();
    exp_ret++;
    checks++; if (retired !== exp_ret) begin errs++; $display("FAIL r0_retired got=%0d exp=%0d", retired, exp_ret); end
    flush = 1;
    set_in(1, 1, 5'd4, 2'd0, 3'd0, 32'h44, 32'h0, 32'h0);
    tick();
    checks++; if (RFWr !== 1'b0) begin errs++; $display("FAIL flush_rfwr got=%b exp=0", RFWr); end
    idle();
    tick();
    checks++; if (retired !== exp_ret) begin errs++; $display("FAIL flush_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask
  task automatic test_reset_mid;
    rst = 0;
    #1;
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      iss_valid = i < 2;
      iss_dst = i == 0 ? 5'd5 : 5'd8;
      set_in(1, i == 7, i == 7 ? 5'd10 : 5'd1, 2'd0, 3'd0, 32'hABC, 32'h0, 32'h0);
      tick();
    end
    idle();
    checks++; if (busy !== 32'h120 || retired !== 32'd7 || RFWr !== 1'b1) begin errs++; $display("FAIL mid_setup got busy=%h ret=%0d rfwr=%b exp 120/7/1", busy, retired, RFWr); end
    #2;
    rst = 0;
    #1;
    checks++; if (RFWr !== 1'b0 || A3 !== 5'd0 || WD !== 32'h0) begin errs++; $display("FAIL mid_async_out got rfwr=%b a3=%0d wd=%h exp 0/0/0", RFWr, A3, WD); end
    checks++; if (busy !== 32'h0 || retired !== 32'h0 || misalign !== 1'b0) begin errs++; $display("FAIL mid_async_state got busy=%h ret=%0d mis=%b exp 0/0/0", busy, retired, misalign); end
    #1;
    rst = 1;
    tick();
    checks++; if (RFWr !== 1'b0 || retired !== 32'h0) begin errs++; $display("FAIL mid_discard got rfwr=%b ret=%0d exp 0/0", RFWr, retired); end
  endtask
  initial begin
    test_reset();
    test_lb();
    test_loads();
    test_scoreboard();
    test_hold();
    test_zero_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
